compose: RTL

Instruction encoder: takes decoded instruction fields (optype, opcode, register indices, funct fields, 21-bit immediate) and emits the 32-bit RISC-V instruction word, i.e. the exact inverse of `decompose`. It sits on the debug-module instruction-injection path and in the bench's stimulus generator. It is a two-stage elastic pipeline with valid/ready on both sides, and it flags immediates the selected format cannot represent.

---
 rtl/common_pkg.sv | 67 ++++++
 rtl/compose_encode.sv | 50 +++++
 rtl/compose.sv | 112 +++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// ----------------------------------------------------------------------------
// common: shared types and constants for the instruction encode/decode blocks.
//   instruction_op_type : instruction format selector (R/I/S/B/U/J/SYS)
//   field_bundle_t      : decoded instruction fields as one packed bundle
//   NOP_INSTRUCTION     : ADDI x0,x0,0, substituted for unencodable bundles
//   imm_fits()          : 1 when the immediate is representable in the format
// ----------------------------------------------------------------------------
package common;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam int IMM_WIDTH         = 21;

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0013;

    // Major opcodes (RV32I base)
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // 3'd7 is deliberately left undefined and is treated as an encode error.
    typedef enum logic [2:0] {
        OP_R   = 3'd0,
        OP_I   = 3'd1,
        OP_S   = 3'd2,
        OP_B   = 3'd3,
        OP_U   = 3'd4,
        OP_J   = 3'd5,
        OP_SYS = 3'd6
    } instruction_op_type;

    typedef struct packed {
        instruction_op_type   optype;
        logic [6:0]           opcode;
        logic [4:0]           rd;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [2:0]           funct3;
        logic [6:0]           funct7;
        logic [IMM_WIDTH-1:0] imm;
    } field_bundle_t;

    // Immediates use the decompose convention: sign-extended to 21 bits,
    // B/J offsets in bytes (bit 0 must be zero), U holds the upper 20 bits.
    function automatic logic imm_fits(input instruction_op_type optype,
                                      input logic [IMM_WIDTH-1:0] imm);
        logic fits;
        case (optype)
            OP_R:             fits = 1'b1;
            OP_I, OP_S, OP_SYS:
                fits = (imm[20:11] == '0) || (imm[20:11] == '1);
            OP_B:
                fits = ((imm[20:12] == '0) || (imm[20:12] == '1)) && !imm[0];
            OP_J:             fits = !imm[0];
            OP_U:             fits = !imm[20];
            default:          fits = 1'b0;
        endcase
        return fits;
    endfunction

endpackage

// File: rtl/compose_encode.sv
// ----------------------------------------------------------------------------
// compose_encode: combinational field bundle -> 32-bit RISC-V word.
//   fields_i : decoded instruction fields
//   word_o   : encoded instruction, or NOP_INSTRUCTION when err_o is set
//   err_o    : bundle cannot be encoded (immediate range/alignment, opcode
//              low bits not 2'b11, or undefined optype)
// ----------------------------------------------------------------------------
module compose_encode
    import common::*;
(
    input  field_bundle_t                 fields_i,
    output logic [INSTRUCTION_WIDTH-1:0]  word_o,
    output logic                          err_o
);

    logic [INSTRUCTION_WIDTH-1:0] raw;
    logic [IMM_WIDTH-1:0]         im;

    assign im = fields_i.imm;

    always_comb begin
        raw = '0;
        case (fields_i.optype)
            OP_R:
                raw = {fields_i.funct7, fields_i.rs2, fields_i.rs1,
                       fields_i.funct3, fields_i.rd, fields_i.opcode};
            OP_I, OP_SYS:
                raw = {im[11:0], fields_i.rs1, fields_i.funct3,
                       fields_i.rd, fields_i.opcode};
            OP_S:
                raw = {im[11:5], fields_i.rs2, fields_i.rs1,
                       fields_i.funct3, im[4:0], fields_i.opcode};
            OP_B:
                raw = {im[12], im[10:5], fields_i.rs2, fields_i.rs1,
                       fields_i.funct3, im[4:1], im[11], fields_i.opcode};
            OP_U:
                raw = {im[19:0], fields_i.rd, fields_i.opcode};
            OP_J:
                raw = {im[20], im[10:1], im[11], im[19:12],
                       fields_i.rd, fields_i.opcode};
            default:
                raw = '0;
        endcase
    end

    assign err_o  = !imm_fits(fields_i.optype, im) ||
                    (fields_i.opcode[1:0] != 2'b11);
    assign word_o = err_o ? NOP_INSTRUCTION : raw;

endmodule

// File: rtl/compose.sv
// ----------------------------------------------------------------------------
// compose: two-stage elastic instruction encoder (inverse of decompose).
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : field bundle handshake (transfer when both high)
//   optype..imm         : decoded instruction fields
//   out_valid/out_ready : instruction word handshake (transfer when both high)
//   instruction, err    : encoded word; err marks a substituted NOP
//   err_count           : saturating count of err words that transferred out
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; once valid is raised the word and err hold until transfer.
// The only combinational path is out_ready -> in_ready.
// ----------------------------------------------------------------------------
module compose
    import common::*;
#(
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  instruction_op_type            optype,
    input  logic [6:0]                    opcode,
    input  logic [4:0]                    rd,
    input  logic [4:0]                    rs1,
    input  logic [4:0]                    rs2,
    input  logic [2:0]                    funct3,
    input  logic [6:0]                    funct7,
    input  logic [IMM_WIDTH-1:0]          imm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INSTRUCTION_WIDTH-1:0]  instruction,
    output logic                          err,
    output logic [ERR_CNT_WIDTH-1:0]      err_count
);

    field_bundle_t                 s1_q, s1_d, in_bundle;
    logic                          s1_valid_q, s1_valid_d;
    logic                          s2_valid_q, s2_valid_d;
    logic [INSTRUCTION_WIDTH-1:0]  instr_q, instr_d;
    logic                          err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0]      err_count_q, err_count_d;

    logic [INSTRUCTION_WIDTH-1:0]  enc_word;
    logic                          enc_err;
    logic                          s2_adv;

    assign in_bundle = '{optype: optype, opcode: opcode, rd: rd, rs1: rs1,
                         rs2: rs2, funct3: funct3, funct7: funct7, imm: imm};

    compose_encode u_encode (
        .fields_i (s1_q),
        .word_o   (enc_word),
        .err_o    (enc_err)
    );

    // S2 moves whenever it is empty or its word is being taken; S1 follows.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        s2_valid_d  = s2_valid_q;
        instr_d     = instr_q;
        err_d       = err_q;
        err_count_d = err_count_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d = in_bundle;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                instr_d = enc_word;
                err_d   = enc_err;
            end
        end

        if (s2_valid_q && out_ready && err_q && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            s2_valid_q  <= 1'b0;
            instr_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            s2_valid_q  <= s2_valid_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign instruction = instr_q;
    assign err         = err_q;
    assign err_count   = err_count_q;

endmodule
